// File: rtl/ps2_rx_pkg.sv
// PS/2 receiver shared types: FSM states, register
// addresses, status bit positions and a parity helper.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int PERR = 8;
  localparam int FERR = 9;
  localparam int OVR  = 10;

  function automatic logic odd_par_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for the PS/2 receiver; a push into a full
// FIFO only lands when a pop frees a slot that cycle.
module ps2_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with byte FIFO and Avalon-MM slave.
// Define PS2_RX_TIMEOUT_EN to abort frames stalled mid-way.
module ps2_rx_frame
  import ps2_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT    = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        ps_clk,
  input  logic        ps_din
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FILT_LEN) + 1;

  logic [1:0]    clk_sy;
  logic [1:0]    din_sy;
  logic          clk_s;
  logic          din_s;
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  state_e        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic          stop_ev;
  logic          tmo_hit;

  logic          enable;
  logic [1:0]    mask;
  logic          perr;
  logic          ferr;
  logic          ovr;

  logic          rd_stb;
  logic          wr_stb;
  logic          sel_data;
  logic          sel_stat;
  logic          sel_mask;
  logic          sel_ctrl;
  logic          push;
  logic          pop;
  logic          perr_set;
  logic          ferr_set;
  logic          ovr_set;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   rdata;
  logic          unused_wd;

  assign clk_s = clk_sy[1];
  assign din_s = din_sy[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sy <= 2'b11;
      din_sy <= 2'b11;
    end else begin
      clk_sy <= {clk_sy[0], ps_clk};
      din_sy <= {din_sy[0], ps_din};
    end
  end

  // Any sample disagreeing with the filtered level restarts nothing
  // only while it persists; a matching sample resets the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILT_LEN - 1)) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
        fall    <= ~clk_s;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;

  assign tmo_hit = enable & (state != IDLE) & ~fall &
                   (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (!enable || state == IDLE || fall || tmo_hit) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  // Without the watchdog a stalled frame simply waits for more edges.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
    end else if (!enable || tmo_hit) begin
      state <= IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!din_s) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: begin
          shreg  <= {din_s, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          par   <= din_s;
          state <= STOP;
        end
        STOP: state <= IDLE;
      endcase
    end
  end

  assign stop_ev  = enable & fall & (state == STOP);
  assign push     = stop_ev & din_s & odd_par_ok(shreg, par);
  assign perr_set = stop_ev & din_s & ~odd_par_ok(shreg, par);
  assign ferr_set = (stop_ev & ~din_s) | tmo_hit;

  assign rd_stb   = chipselect & ~read_n;
  assign wr_stb   = chipselect & ~write_n;
  assign sel_data = (address == ADDR_DATA);
  assign sel_stat = (address == ADDR_STATUS);
  assign sel_mask = (address == ADDR_MASK);
  assign sel_ctrl = (address == ADDR_CTRL);
  assign pop      = rd_stb & sel_data & ~empty;
  assign ovr_set  = push & full & ~pop;

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (shreg),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr   <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
      mask   <= '0;
      enable <= 1'b0;
    end else begin
      if (perr_set) perr <= 1'b1;
      else if (wr_stb && sel_stat && writedata[PERR]) perr <= 1'b0;
      if (ferr_set) ferr <= 1'b1;
      else if (wr_stb && sel_stat && writedata[FERR]) ferr <= 1'b0;
      if (ovr_set) ovr <= 1'b1;
      else if (wr_stb && sel_stat && writedata[OVR]) ovr <= 1'b0;
      if (wr_stb && sel_mask) mask   <= writedata[1:0];
      if (wr_stb && sel_ctrl) enable <= writedata[0];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_data: if (!empty) rdata = {23'd0, 1'b1, head};
      sel_stat: rdata = {21'd0, ovr, ferr, perr, 3'd0, 5'(count)};
      sel_mask: rdata = {30'd0, mask};
      sel_ctrl: rdata = {31'd0, enable};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rdata;
  end

  assign irq = (mask[0] & ~empty) | (mask[1] & (perr | ferr | ovr));

  assign unused_wd = ^{writedata[31:11], writedata[7:2]};

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: register reads queue their
// expected values, a monitor checks readdata one cycle later.
module tb_ps2_rx_frame;

  localparam int TIMEOUT = 8192;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        ps_clk = 1'b1;
  logic        ps_din = 1'b1;

  ps2_rx_frame #(
    .FIFO_DEPTH (8),
    .FILT_LEN   (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .ps_clk     (ps_clk),
    .ps_din     (ps_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic rd_v;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_v <= 1'b0;
    else          rd_v <= chipselect & ~read_n;
  end

  always @(negedge clk) begin
    if (rd_v) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h", readdata);
      end else begin
        mon_e = sb.pop_front();
        if (readdata !== mon_e.val) begin
          errors++;
          $display("FAIL %s got=%h exp=%h",
                   mon_e.name, readdata, mon_e.val);
        end
      end
    end
  end

  task automatic rd(input logic [1:0] a,
                    input logic [31:0] e,
                    input string nm);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    sb.push_back('{name: nm, val: e});
    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_irq(input logic e, input string nm);
    @(negedge clk);
    checks++;
    if (irq !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, irq, e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps_din = b;
    wait_cyc(20);
    ps_clk = 1'b0;
    wait_cyc(40);
    ps_clk = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic bad_par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ bad_par);
    send_bit(stop);
    ps_din = 1'b1;
    wait_cyc(30);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(2);

    check_irq(1'b0, "reset_irq");
    rd(2'd1, 32'h0, "reset_status");
    rd(2'd0, 32'h0, "reset_data");
    rd(2'd2, 32'h0, "reset_mask");
    rd(2'd3, 32'h0, "reset_ctrl");

    send_frame(8'h77, 1'b0, 1'b1);
    rd(2'd1, 32'h0, "gated_status");

    wr(2'd3, 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd3, 32'h1, "ctrl_rb");
    rd(2'd2, 32'h1, "mask_rb");

    send_frame(8'h1C, 1'b0, 1'b1);
    rd(2'd1, 32'h1, "t1_count");
    check_irq(1'b1, "t1_irq_rise");
    rd(2'd0, 32'h11C, "t1_data");
    rd(2'd1, 32'h0, "t1_count0");
    check_irq(1'b0, "t1_irq_fall");

    send_frame(8'hA5, 1'b1, 1'b1);
    rd(2'd1, 32'h100, "perr_set");
    wr(2'd1, 32'h100);
    rd(2'd1, 32'h0, "perr_clr");

    wr(2'd2, 32'h2);
    send_frame(8'h55, 1'b0, 1'b0);
    rd(2'd1, 32'h200, "ferr_set");
    check_irq(1'b1, "irq_err");
    wr(2'd1, 32'h200);
    check_irq(1'b0, "irq_err_clr");
    wr(2'd2, 32'h1);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    rd(2'd1, 32'h408, "ovr_status");
    check_irq(1'b1, "irq_ne");
    for (int i = 1; i <= 8; i++)
      rd(2'd0, 32'h100 | 32'(i), $sformatf("ovf_data%0d", i));
    rd(2'd0, 32'h0, "empty_data");
    rd(2'd1, 32'h400, "ovr_keep");
    wr(2'd1, 32'h400);
    rd(2'd1, 32'h0, "ovr_clr");

    ps_din = 1'b0;
    ps_clk = 1'b0;
    wait_cyc(3);
    ps_clk = 1'b1;
    wait_cyc(30);
    ps_din = 1'b1;
    wait_cyc(20);
    rd(2'd1, 32'h0, "glitch_status");
    send_frame(8'h3A, 1'b0, 1'b1);
    rd(2'd0, 32'h13A, "glitch_next");

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps_din = 1'b1;
`ifdef PS2_RX_TIMEOUT_EN
    wait_cyc(TIMEOUT + 100);
    rd(2'd1, 32'h200, "tmo_ferr");
    wr(2'd1, 32'h200);
    send_frame(8'h3A, 1'b0, 1'b1);
    rd(2'd0, 32'h13A, "tmo_next");
`else
    wait_cyc(300);
    rd(2'd1, 32'h0, "stall_noerr");
    wr(2'd3, 32'h0);
    wr(2'd3, 32'h1);
    rd(2'd1, 32'h0, "abort_noerr");
    send_frame(8'h3A, 1'b0, 1'b1);
    rd(2'd0, 32'h13A, "abort_next");
`endif

    wait_cyc(5);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_reads got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
